// File: rtl/rs_collapse_queue.sv
`default_nettype none
// ============================================================================
// Module   : rs_collapse_queue
// Purpose  : Age-ordered reservation station built as a collapsing queue.
//            Slot 0 always holds the oldest instruction. The station wakes
//            operands from the CDB, bypasses the CDB into newly dispatched
//            entries, and issues the oldest fully-ready entry through a
//            valid/ready issue register. It also reports a free-slot margin
//            and a sticky overflow flag.
// Ports    : clk_in, rst_in (sync, active high), rdy_in (global enable),
//            flush_in (misprediction flush),
//            disp_*_in      dispatch write port,
//            cdb_tag_in / cdb_data_in  packed CDB broadcast channels,
//            rs_rdy_out, count_out, err_overflow_out  status,
//            iss_valid_out / iss_ready_in / iss_*_out  issue handshake.
// Revision : 1.0  initial release
// ============================================================================
module rs_collapse_queue #(
  parameter int ENTRIES   = 8,
  parameter int TAG_W     = 4,
  parameter int DATA_W    = 32,
  parameter int PC_W      = 32,
  parameter int OP_W      = 6,
  parameter int CDB_PORTS = 2,
  parameter int CNT_W     = $clog2(ENTRIES + 1)
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        rdy_in,
  input  logic                        flush_in,
  input  logic                        disp_en_in,
  input  logic [TAG_W-1:0]            disp_qj_in,
  input  logic [TAG_W-1:0]            disp_qk_in,
  input  logic [DATA_W-1:0]           disp_vj_in,
  input  logic [DATA_W-1:0]           disp_vk_in,
  input  logic [DATA_W-1:0]           disp_a_in,
  input  logic [TAG_W-1:0]            disp_dest_in,
  input  logic [PC_W-1:0]             disp_pc_in,
  input  logic [OP_W-1:0]             disp_op_in,
  input  logic [CDB_PORTS*TAG_W-1:0]  cdb_tag_in,
  input  logic [CDB_PORTS*DATA_W-1:0] cdb_data_in,
  output logic                        rs_rdy_out,
  output logic [CNT_W-1:0]            count_out,
  output logic                        err_overflow_out,
  output logic                        iss_valid_out,
  input  logic                        iss_ready_in,
  output logic [DATA_W-1:0]           iss_vj_out,
  output logic [DATA_W-1:0]           iss_vk_out,
  output logic [DATA_W-1:0]           iss_a_out,
  output logic [TAG_W-1:0]            iss_dest_out,
  output logic [PC_W-1:0]             iss_pc_out,
  output logic [OP_W-1:0]             iss_op_out
);

  typedef struct packed {
    logic [TAG_W-1:0]  qj;
    logic [TAG_W-1:0]  qk;
    logic [DATA_W-1:0] vj;
    logic [DATA_W-1:0] vk;
    logic [DATA_W-1:0] a;
    logic [TAG_W-1:0]  dest;
    logic [PC_W-1:0]   pc;
    logic [OP_W-1:0]   op;
  } entry_t;

  localparam logic [CNT_W-1:0] c_full    = CNT_W'(ENTRIES);
  localparam logic [CNT_W-1:0] c_rdy_lim = CNT_W'(ENTRIES - 2);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  entry_t              r_slot [ENTRIES];
  logic [CNT_W-1:0]    r_count;
  logic                r_ovf;
  logic                r_iss_valid;
  logic [DATA_W-1:0]   r_iss_vj;
  logic [DATA_W-1:0]   r_iss_vk;
  logic [DATA_W-1:0]   r_iss_a;
  logic [TAG_W-1:0]    r_iss_dest;
  logic [PC_W-1:0]     r_iss_pc;
  logic [OP_W-1:0]     r_iss_op;

  // --------------------------------------------------------------------------
  // CDB unpacking
  // --------------------------------------------------------------------------
  logic [TAG_W-1:0]    w_cdb_tag  [CDB_PORTS];
  logic [DATA_W-1:0]   w_cdb_data [CDB_PORTS];

  generate
    for (genvar p = 0; p < CDB_PORTS; p++) begin : g_cdb
      assign w_cdb_tag[p]  = cdb_tag_in[p*TAG_W +: TAG_W];
      assign w_cdb_data[p] = cdb_data_in[p*DATA_W +: DATA_W];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Oldest-ready select. Because the queue is age ordered, the first ready
  // slot from index 0 is the oldest. w_le[i] marks slots at or above the
  // selected one, i.e. the slots that collapse when an issue happens.
  // --------------------------------------------------------------------------
  logic [ENTRIES-1:0]  w_ready;
  logic [ENTRIES-1:0]  w_onehot;
  logic [ENTRIES-1:0]  w_le;
  logic                w_seen;
  entry_t              w_sel;

  always_comb begin
    w_ready  = '0;
    w_onehot = '0;
    w_le     = '0;
    w_seen   = 1'b0;
    w_sel    = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      w_ready[i]  = (CNT_W'(i) < r_count) && (r_slot[i].qj == '0) && (r_slot[i].qk == '0);
      w_onehot[i] = w_ready[i] && !w_seen;
      w_seen      = w_seen | w_ready[i];
      w_le[i]     = w_seen;
      if (w_onehot[i]) begin
        w_sel = r_slot[i];
      end
    end
  end

  logic w_iss_free;
  logic w_issue;
  logic w_full;
  logic w_disp_ok;
  logic w_ovf_set;
  logic [CNT_W-1:0] w_wp;
  logic [CNT_W-1:0] w_count_nxt;

  assign w_iss_free = !r_iss_valid || iss_ready_in;
  assign w_issue    = w_iss_free && w_seen;
  assign w_full     = (r_count == c_full);
  // A same-cycle issue frees a slot, so a dispatch at full is still taken.
  assign w_disp_ok  = disp_en_in && (!w_full || w_issue);
  assign w_ovf_set  = disp_en_in && w_full && !w_issue;
  assign w_wp       = w_issue ? (r_count - CNT_W'(1)) : r_count;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_issue, w_disp_ok})
      2'b10:   w_count_nxt = r_count - CNT_W'(1);
      2'b01:   w_count_nxt = r_count + CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // --------------------------------------------------------------------------
  // Dispatch entry with CDB bypass. Ports are scanned from highest to lowest
  // so that the lowest matching port is the last writer and wins.
  // --------------------------------------------------------------------------
  entry_t w_disp;

  always_comb begin
    w_disp.qj   = disp_qj_in;
    w_disp.qk   = disp_qk_in;
    w_disp.vj   = disp_vj_in;
    w_disp.vk   = disp_vk_in;
    w_disp.a    = disp_a_in;
    w_disp.dest = disp_dest_in;
    w_disp.pc   = disp_pc_in;
    w_disp.op   = disp_op_in;
    for (int p = CDB_PORTS - 1; p >= 0; p--) begin
      if ((w_cdb_tag[p] != '0) && (w_cdb_tag[p] == disp_qj_in)) begin
        w_disp.qj = '0;
        w_disp.vj = w_cdb_data[p];
      end
      if ((w_cdb_tag[p] != '0) && (w_cdb_tag[p] == disp_qk_in)) begin
        w_disp.qk = '0;
        w_disp.vk = w_cdb_data[p];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next slot contents: collapse, then wake up at the post-shift location,
  // then overlay the dispatched entry at the write position. Wakeup compares
  // against the pre-wakeup tag so a lower port can still override a higher.
  // --------------------------------------------------------------------------
  entry_t w_shift [ENTRIES];
  entry_t w_nslot [ENTRIES];

  always_comb begin
    for (int i = 0; i < ENTRIES - 1; i++) begin
      w_shift[i] = (w_issue && w_le[i]) ? r_slot[i+1] : r_slot[i];
    end
    // The top slot has nothing above it; after a collapse it becomes
    // don't-care, so it simply keeps its contents.
    w_shift[ENTRIES-1] = r_slot[ENTRIES-1];

    for (int i = 0; i < ENTRIES; i++) begin
      w_nslot[i] = w_shift[i];
      for (int p = CDB_PORTS - 1; p >= 0; p--) begin
        if ((w_cdb_tag[p] != '0) && (w_cdb_tag[p] == w_shift[i].qj)) begin
          w_nslot[i].qj = '0;
          w_nslot[i].vj = w_cdb_data[p];
        end
        if ((w_cdb_tag[p] != '0) && (w_cdb_tag[p] == w_shift[i].qk)) begin
          w_nslot[i].qk = '0;
          w_nslot[i].vk = w_cdb_data[p];
        end
      end
      if (w_disp_ok && (CNT_W'(i) == w_wp)) begin
        w_nslot[i] = w_disp;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Sequential state
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_slot[i] <= '0;
      end
      r_count     <= '0;
      r_ovf       <= 1'b0;
      r_iss_valid <= 1'b0;
      r_iss_vj    <= '0;
      r_iss_vk    <= '0;
      r_iss_a     <= '0;
      r_iss_dest  <= '0;
      r_iss_pc    <= '0;
      r_iss_op    <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        // Slot contents become don't-care once count is zero.
        r_count     <= '0;
        r_iss_valid <= 1'b0;
      end else begin
        for (int i = 0; i < ENTRIES; i++) begin
          r_slot[i] <= w_nslot[i];
        end
        r_count <= w_count_nxt;
        if (w_ovf_set) begin
          r_ovf <= 1'b1;
        end
        if (w_issue) begin
          r_iss_valid <= 1'b1;
          r_iss_vj    <= w_sel.vj;
          r_iss_vk    <= w_sel.vk;
          r_iss_a     <= w_sel.a;
          r_iss_dest  <= w_sel.dest;
          r_iss_pc    <= w_sel.pc;
          r_iss_op    <= w_sel.op;
        end else if (w_iss_free) begin
          r_iss_valid <= 1'b0;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign rs_rdy_out       = (r_count <= c_rdy_lim);
  assign count_out        = r_count;
  assign err_overflow_out = r_ovf;
  assign iss_valid_out    = r_iss_valid;
  assign iss_vj_out       = r_iss_vj;
  assign iss_vk_out       = r_iss_vk;
  assign iss_a_out        = r_iss_a;
  assign iss_dest_out     = r_iss_dest;
  assign iss_pc_out       = r_iss_pc;
  assign iss_op_out       = r_iss_op;

endmodule
`default_nettype wire

// File: tb/tb_rs_collapse_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_rs_collapse_queue
// Purpose  : Self-checking bench for rs_collapse_queue. A queue-based model
//            of the reservation station is advanced on every rising edge and
//            compared against the DUT on every falling edge. Directed
//            scenarios add literal expectations, then a randomized phase runs.
// Revision : 1.0  initial release
// ============================================================================
module tb_rs_collapse_queue;

  localparam int ENTRIES = 8;
  localparam int TAG_W   = 4;
  localparam int DATA_W  = 32;
  localparam int PC_W    = 32;
  localparam int OP_W    = 6;
  localparam int CDB_P   = 2;
  localparam int CNT_W   = $clog2(ENTRIES + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst, rdy, flush, disp_en, iss_ready;
  logic [TAG_W-1:0]        d_qj, d_qk, d_dest;
  logic [DATA_W-1:0]       d_vj, d_vk, d_a;
  logic [PC_W-1:0]         d_pc;
  logic [OP_W-1:0]         d_op;
  logic [CDB_P*TAG_W-1:0]  cdb_tag;
  logic [CDB_P*DATA_W-1:0] cdb_data;

  logic                    rs_rdy, ovf, iss_valid;
  logic [CNT_W-1:0]        count;
  logic [DATA_W-1:0]       iss_vj, iss_vk, iss_a;
  logic [TAG_W-1:0]        iss_dest;
  logic [PC_W-1:0]         iss_pc;
  logic [OP_W-1:0]         iss_op;

  rs_collapse_queue #(
    .ENTRIES(ENTRIES), .TAG_W(TAG_W), .DATA_W(DATA_W), .PC_W(PC_W),
    .OP_W(OP_W), .CDB_PORTS(CDB_P)
  ) dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .flush_in(flush),
    .disp_en_in(disp_en), .disp_qj_in(d_qj), .disp_qk_in(d_qk),
    .disp_vj_in(d_vj), .disp_vk_in(d_vk), .disp_a_in(d_a),
    .disp_dest_in(d_dest), .disp_pc_in(d_pc), .disp_op_in(d_op),
    .cdb_tag_in(cdb_tag), .cdb_data_in(cdb_data),
    .rs_rdy_out(rs_rdy), .count_out(count), .err_overflow_out(ovf),
    .iss_valid_out(iss_valid), .iss_ready_in(iss_ready),
    .iss_vj_out(iss_vj), .iss_vk_out(iss_vk), .iss_a_out(iss_a),
    .iss_dest_out(iss_dest), .iss_pc_out(iss_pc), .iss_op_out(iss_op)
  );

  int tests = 0;
  int fails = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // --------------------------------------------------------------------------
  // Behavioural model: the station is a plain queue, oldest at the front.
  // --------------------------------------------------------------------------
  typedef struct {
    logic [TAG_W-1:0]  qj, qk, dest;
    logic [DATA_W-1:0] vj, vk, a;
    logic [PC_W-1:0]   pc;
    logic [OP_W-1:0]   op;
  } ent_t;

  ent_t mq[$];
  ent_t m_iss;
  bit   m_iss_v = 0;
  bit   m_ovf   = 0;
  bit   m_init  = 0;

  function automatic logic [TAG_W-1:0] ctag(int p);
    logic [CDB_P*TAG_W-1:0] t;
    t = cdb_tag;
    return t[p*TAG_W +: TAG_W];
  endfunction

  function automatic logic [DATA_W-1:0] cdat(int p);
    logic [CDB_P*DATA_W-1:0] d;
    d = cdb_data;
    return d[p*DATA_W +: DATA_W];
  endfunction

  // Resolve one operand against the CDB: first (lowest) matching port wins.
  function automatic void resolve(inout logic [TAG_W-1:0] q, inout logic [DATA_W-1:0] v);
    for (int p = 0; p < CDB_P; p++) begin
      if (q != 0 && ctag(p) == q) begin
        v = cdat(p);
        q = 0;
        break;
      end
    end
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_iss   = '{default: '0};
      m_iss_v = 0;
      m_ovf   = 0;
      m_init  = 1;
    end else if (!rdy) begin
      // frozen
    end else if (flush) begin
      mq.delete();
      m_iss_v = 0;
    end else begin
      bit   issued;
      int   idx;
      ent_t e;
      issued = 0;
      if (!m_iss_v || iss_ready) begin
        idx = -1;
        for (int i = 0; i < mq.size(); i++) begin
          if (mq[i].qj == 0 && mq[i].qk == 0) begin
            idx = i;
            break;
          end
        end
        if (idx >= 0) begin
          m_iss = mq[idx];
          mq.delete(idx);
          m_iss_v = 1;
          issued  = 1;
        end else begin
          m_iss_v = 0;
        end
      end
      for (int i = 0; i < mq.size(); i++) begin
        e = mq[i];
        resolve(e.qj, e.vj);
        resolve(e.qk, e.vk);
        mq[i] = e;
      end
      if (disp_en) begin
        if (mq.size() == ENTRIES) begin
          m_ovf = 1;
        end else begin
          e.qj = d_qj; e.qk = d_qk; e.vj = d_vj; e.vk = d_vk;
          e.a = d_a; e.dest = d_dest; e.pc = d_pc; e.op = d_op;
          resolve(e.qj, e.vj);
          resolve(e.qk, e.vk);
          mq.push_back(e);
        end
      end
    end
  end

  // Single compare process, away from the active edge.
  always @(negedge clk) begin
    if (m_init) begin
      chk("count", 64'(count), 64'(mq.size()));
      chk("rs_rdy", 64'(rs_rdy), 64'(mq.size() <= ENTRIES - 2));
      chk("overflow", 64'(ovf), 64'(m_ovf));
      chk("iss_valid", 64'(iss_valid), 64'(m_iss_v));
      if (m_iss_v) begin
        chk("iss_vj", 64'(iss_vj), 64'(m_iss.vj));
        chk("iss_vk", 64'(iss_vk), 64'(m_iss.vk));
        chk("iss_a", 64'(iss_a), 64'(m_iss.a));
        chk("iss_dest", 64'(iss_dest), 64'(m_iss.dest));
        chk("iss_pc", 64'(iss_pc), 64'(m_iss.pc));
        chk("iss_op", 64'(iss_op), 64'(m_iss.op));
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    disp_en = 0; flush = 0; cdb_tag = '0; cdb_data = '0;
  endtask

  task automatic disp(input logic [TAG_W-1:0] qj, input logic [TAG_W-1:0] qk,
                      input logic [DATA_W-1:0] vj, input logic [DATA_W-1:0] vk,
                      input logic [TAG_W-1:0] dest);
    disp_en = 1; d_qj = qj; d_qk = qk; d_vj = vj; d_vk = vk; d_dest = dest;
    d_a = DATA_W'(dest) << 4; d_pc = PC_W'(dest) << 2; d_op = OP_W'(dest);
  endtask

  logic [TAG_W-1:0] drain_exp [8];

  initial begin
    rst = 1; rdy = 1; flush = 0; iss_ready = 0;
    disp_en = 0; d_qj = 0; d_qk = 0; d_vj = 0; d_vk = 0; d_a = 0;
    d_dest = 0; d_pc = 0; d_op = 0; cdb_tag = '0; cdb_data = '0;
    tick(); tick();
    rst = 0;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_rs_rdy", 64'(rs_rdy), 64'd1);
    chk("rst_iss_valid", 64'(iss_valid), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_iss_vj", 64'(iss_vj), 64'd0);
    chk("rst_iss_pc", 64'(iss_pc), 64'd0);

    // Age order: A waits on tag 3, B and C overtake it.
    iss_ready = 1;
    disp(3, 0, 0, 32'h11, 1); tick();
    disp(0, 0, 32'h22, 32'h22, 2); tick();
    disp(0, 0, 32'h33, 32'h33, 3); tick();
    chk("age_B_dest", 64'(iss_dest), 64'd2);
    idle(); tick();
    chk("age_C_dest", 64'(iss_dest), 64'd3);
    cdb_tag = 8'h03; cdb_data = {32'h0, 32'h55}; tick();
    chk("age_wait_valid", 64'(iss_valid), 64'd0);
    idle(); tick();
    chk("age_A_dest", 64'(iss_dest), 64'd1);
    chk("age_A_vj", 64'(iss_vj), 64'h55);
    tick();
    chk("age_empty", 64'(count), 64'd0);

    // Dispatch bypass on CDB port 1.
    disp(0, 5, 32'h7, 32'h0, 4);
    cdb_tag = 8'h50; cdb_data = {32'hDEAD, 32'h0}; tick();
    idle(); tick();
    chk("byp_dest", 64'(iss_dest), 64'd4);
    chk("byp_vk", 64'(iss_vk), 64'hDEAD);
    tick();

    // Backpressure, full boundary, collapse.
    iss_ready = 0;
    for (int i = 1; i <= 8; i++) begin
      disp(0, 0, 32'(i), 32'(i + 100), TAG_W'(i)); tick();
    end
    chk("bp_count7", 64'(count), 64'd7);
    chk("bp_rs_rdy", 64'(rs_rdy), 64'd0);
    chk("bp_hold_dest", 64'(iss_dest), 64'd1);
    disp(0, 0, 9, 109, 9); tick();
    chk("full_count", 64'(count), 64'd8);
    disp(0, 0, 10, 110, 10); tick();
    chk("drop_count", 64'(count), 64'd8);
    chk("drop_ovf", 64'(ovf), 64'd1);
    iss_ready = 1;
    disp(0, 0, 11, 111, 11); tick();
    chk("full_issue_count", 64'(count), 64'd8);
    chk("full_issue_dest", 64'(iss_dest), 64'd2);
    idle();
    drain_exp = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd11};
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("drain_valid", 64'(iss_valid), 64'd1);
      chk("drain_dest", 64'(iss_dest), 64'(drain_exp[k]));
    end
    chk("drain_count", 64'(count), 64'd0);
    tick();

    // Freeze then flush during an unaccepted issue.
    iss_ready = 0;
    for (int i = 1; i <= 4; i++) begin
      disp(0, 0, 32'(i), 32'(i), TAG_W'(i)); tick();
    end
    chk("fl_pre_count", 64'(count), 64'd3);
    rdy = 0; flush = 1; disp(0, 0, 1, 1, 12); tick();
    chk("frz_count", 64'(count), 64'd3);
    chk("frz_valid", 64'(iss_valid), 64'd1);
    rdy = 1; tick();
    chk("fl_count", 64'(count), 64'd0);
    chk("fl_valid", 64'(iss_valid), 64'd0);
    chk("fl_ovf_kept", 64'(ovf), 64'd1);
    idle(); tick();
    chk("fl_disp_lost", 64'(count), 64'd0);

    // Randomized phase.
    for (int c = 0; c < 4000; c++) begin
      rst       = ($urandom_range(0, 999) == 0);
      rdy       = ($urandom_range(0, 99) >= 5);
      flush     = ($urandom_range(0, 99) < 2);
      iss_ready = ($urandom_range(0, 99) < 65);
      disp_en   = ($urandom_range(0, 99) < 55);
      d_qj   = $urandom_range(0, 1) ? TAG_W'($urandom_range(1, 7)) : '0;
      d_qk   = $urandom_range(0, 1) ? TAG_W'($urandom_range(1, 7)) : '0;
      d_vj   = $urandom; d_vk = $urandom; d_a = $urandom;
      d_dest = TAG_W'($urandom); d_pc = $urandom; d_op = OP_W'($urandom);
      for (int p = 0; p < CDB_P; p++) begin
        cdb_tag[p*TAG_W +: TAG_W]   = $urandom_range(0, 1) ? TAG_W'($urandom_range(1, 7)) : '0;
        cdb_data[p*DATA_W +: DATA_W] = $urandom;
      end
      tick();
    end
    rst = 0; rdy = 1; idle();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
